// File: rtl/adc_channel_scanner_if.sv
// Result bus from the ADC scanner to the channel distributor.
// The scanner drives it through the master modport; the distributor listens through the slave modport.
interface adc_channel_scanner_if;
  logic [11:0] data;
  logic [4:0]  address;
  logic        valid;
  logic        frame_start;

  modport master (
    output data,
    output address,
    output valid,
    output frame_start
  );

  modport slave (
    input data,
    input address,
    input valid,
    input frame_start
  );
endinterface

// File: rtl/adc_channel_scanner.sv
// Scans a multiplexed 12-bit SPI ADC channel by channel.
// Each result is presented to the distributor as data/address with a multi-cycle valid pulse.
module adc_channel_scanner #(
  parameter int NUM_CH     = 32,
  parameter int CLK_DIV    = 2,
  parameter int SETTLE_CYC = 4,
  parameter int VALID_HOLD = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         adc_miso,
  output logic                         adc_sclk,
  output logic                         adc_cs_n,
  output logic [4:0]                   mux_addr,
  adc_channel_scanner_if.master        res
);

  typedef enum logic [2:0] {IDLE, SETTLE, CONVERT, PRESENT, GAP} state_t;

  localparam logic [4:0]  LAST_CH     = 5'(NUM_CH - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(VALID_HOLD - 1);
  localparam logic [15:0] DIV_LAST    = 16'(CLK_DIV - 1);

  state_t      state_reg, state_next;
  logic [4:0]  ch_reg, ch_next, ch_inc;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] div_reg, div_next;
  logic [4:0]  tog_reg, tog_next;
  logic [11:0] shift_reg, shift_next;
  logic        sclk_reg, sclk_next;
  logic        cs_n_reg, cs_n_next;
  logic [4:0]  mux_reg, mux_next;
  logic [11:0] data_reg, data_next;
  logic [4:0]  addr_reg, addr_next;
  logic        valid_reg, valid_next;
  logic        fs_reg, fs_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ch_reg    <= 5'd0;
      cnt_reg   <= 16'd0;
      div_reg   <= 16'd0;
      tog_reg   <= 5'd0;
      shift_reg <= 12'd0;
      sclk_reg  <= 1'b0;
      cs_n_reg  <= 1'b1;
      mux_reg   <= 5'd0;
      data_reg  <= 12'd0;
      addr_reg  <= 5'd0;
      valid_reg <= 1'b0;
      fs_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      cnt_reg   <= cnt_next;
      div_reg   <= div_next;
      tog_reg   <= tog_next;
      shift_reg <= shift_next;
      sclk_reg  <= sclk_next;
      cs_n_reg  <= cs_n_next;
      mux_reg   <= mux_next;
      data_reg  <= data_next;
      addr_reg  <= addr_next;
      valid_reg <= valid_next;
      fs_reg    <= fs_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    cnt_next   = cnt_reg;
    div_next   = div_reg;
    tog_next   = tog_reg;
    shift_next = shift_reg;
    sclk_next  = sclk_reg;
    cs_n_next  = cs_n_reg;
    mux_next   = mux_reg;
    data_next  = data_reg;
    addr_next  = addr_reg;
    valid_next = valid_reg;
    fs_next    = 1'b0;
    ch_inc     = (ch_reg == LAST_CH) ? 5'd0 : ch_reg + 5'd1;

    case (state_reg)
      IDLE: begin
        cnt_next = 16'd0;
        if (enable) begin
          mux_next   = ch_reg;
          fs_next    = (ch_reg == 5'd0);
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_reg == SETTLE_LAST) begin
          cnt_next   = 16'd0;
          div_next   = 16'd0;
          tog_next   = 5'd0;
          cs_n_next  = 1'b0;
          state_next = CONVERT;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      CONVERT: begin
        if (div_reg == DIV_LAST) begin
          div_next  = 16'd0;
          sclk_next = ~sclk_reg;
          // A 12-bit register keeps exactly the last 12 of the 16 bits, dropping the leading nibble.
          if (!sclk_reg)
            shift_next = {shift_reg[10:0], adc_miso};
          if (tog_reg == 5'd31) begin
            cs_n_next  = 1'b1;
            data_next  = shift_reg;
            addr_next  = ch_reg;
            valid_next = 1'b1;
            cnt_next   = 16'd0;
            state_next = PRESENT;
          end else begin
            tog_next = tog_reg + 5'd1;
          end
        end else begin
          div_next = div_reg + 16'd1;
        end
      end
      PRESENT: begin
        if (cnt_reg == HOLD_LAST) begin
          valid_next = 1'b0;
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      GAP: begin
        ch_next  = ch_inc;
        cnt_next = 16'd0;
        if (enable) begin
          mux_next   = ch_inc;
          fs_next    = (ch_inc == 5'd0);
          state_next = SETTLE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign adc_sclk        = sclk_reg;
  assign adc_cs_n        = cs_n_reg;
  assign mux_addr        = mux_reg;
  assign res.data        = data_reg;
  assign res.address     = addr_reg;
  assign res.valid       = valid_reg;
  assign res.frame_start = fs_reg;

endmodule
